// File: rtl/wb_bus_arbiter_2m.sv
// Two-master Wishbone arbiter: CPU data bus (m0) and instruction bus (m1)
// share one slave port. Grants are held for a whole bus cycle, ties resolve
// round-robin or fixed, and a watchdog aborts cycles the slave never acks.
module wb_bus_arbiter_2m #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o,
  output logic            timeout_o
);

  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
  localparam bit RR = (RR_EN != 0);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t        state;
  logic [1:0]    gnt;
  logic          last_m1;
  logic [WW-1:0] wdog;
  logic          timeout_q;

  logic req0, req1, pick_m1, busy, owner_cyc, owner_stb, wd_hit;

  // Request decode, tie-break choice and watchdog limit detection
  always_comb begin
    req0      = m0_cyc_i & m0_stb_i;
    req1      = m1_cyc_i & m1_stb_i;
    pick_m1   = req1 & (~req0 | (RR & ~last_m1));
    busy      = (state == BUSY);
    owner_cyc = gnt[1] ? m1_cyc_i : m0_cyc_i;
    owner_stb = gnt[1] ? m1_stb_i : m0_stb_i;
    wd_hit    = WD_EN & busy & owner_stb & ~s_ack_i & ~s_err_i & (wdog == WD_LAST);
  end

  // Arbitration FSM with grant, round-robin history and watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      last_m1   <= 1'b1;
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timeout_q <= 1'b0;
          if (req0 | req1) begin
            gnt     <= pick_m1 ? 2'b10 : 2'b01;
            last_m1 <= pick_m1;
            wdog    <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (s_ack_i | s_err_i) begin
            wdog <= '0;
          end else if (owner_stb) begin
            wdog <= wdog + 1'b1;
          end
          if (wd_hit) begin
            state     <= ABORT;
            timeout_q <= 1'b1;
          end else if (!owner_cyc) begin
            state <= IDLE;
            gnt   <= 2'b00;
          end
        end
        ABORT: begin
          state     <= IDLE;
          gnt       <= 2'b00;
          timeout_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          gnt       <= 2'b00;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  // Shared slave bus follows the owner only while a cycle is in progress
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (busy) begin
      s_adr_o = gnt[1] ? m1_adr_i : m0_adr_i;
      s_dat_o = gnt[1] ? m1_dat_i : m0_dat_i;
      s_sel_o = gnt[1] ? m1_sel_i : m0_sel_i;
      s_we_o  = gnt[1] ? m1_we_i  : m0_we_i;
      s_cyc_o = owner_cyc;
      s_stb_o = owner_stb;
    end
  end

  // Slave responses routed to the owner only; abort forces an error pulse
  always_comb begin
    m0_dat_o  = s_dat_i;
    m1_dat_o  = s_dat_i;
    m0_ack_o  = busy & gnt[0] & s_ack_i & m0_stb_i;
    m1_ack_o  = busy & gnt[1] & s_ack_i & m1_stb_i;
    m0_err_o  = (busy & gnt[0] & s_err_i & m0_stb_i) | ((state == ABORT) & gnt[0]);
    m1_err_o  = (busy & gnt[1] & s_err_i & m1_stb_i) | ((state == ABORT) & gnt[1]);
    gnt_o     = gnt;
    timeout_o = timeout_q;
  end

endmodule

// File: tb/tb_wb_bus_arbiter_2m.sv
// Bench for wb_bus_arbiter_2m: instance a is round-robin with an 8-cycle
// watchdog, instance b is fixed priority with the watchdog disabled.
module tb_wb_bus_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0, s_dat = '0;
  logic [3:0]  m0_sel = '0, m1_sel = '0;
  logic        m0_we = 0, m0_cyc = 0, m0_stb = 0, m1_we = 0, m1_cyc = 0, m1_stb = 0;
  logic        s_ack = 0, s_err = 0;

  logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat, b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
  logic [3:0]  a_s_sel, b_s_sel;
  logic [1:0]  a_gnt, b_gnt;
  logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_we, a_s_cyc, a_s_stb, a_to;
  logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_we, b_s_cyc, b_s_stb, b_to;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter_2m #(.AW(32), .DW(32), .RR_EN(1), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack),
    .m0_err_o(a_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack),
    .m1_err_o(a_m1_err),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel), .s_we_o(a_s_we),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .s_err_i(s_err), .gnt_o(a_gnt), .timeout_o(a_to)
  );

  wb_bus_arbiter_2m #(.AW(32), .DW(32), .RR_EN(0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack),
    .m0_err_o(b_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack),
    .m1_err_o(b_m1_err),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel), .s_we_o(b_s_we),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .s_err_i(s_err), .gnt_o(b_gnt), .timeout_o(b_to)
  );

  typedef struct {
    bit m0r, m1r, ack, err;
    logic [1:0] gnt_a, gnt_b;
    bit scyc, a0, a1, e0, e1, to;
  } vec_t;

  vec_t vec[17];

  // Behavioural reference: who owns the bus, how many unacked strobes so far
  int mdl_owner[2];
  int mdl_last[2];
  int mdl_unack[2];
  bit mdl_abort[2];
  int mdl_rr[2] = '{1, 0};
  int mdl_to[2] = '{8, 0};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    m0_cyc = v.m0r; m0_stb = v.m0r;
    m1_cyc = v.m1r; m1_stb = v.m1r;
    s_ack  = v.ack; s_err  = v.err;
  endtask

  task automatic clearInputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
    s_ack = 0; s_err = 0; s_dat = '0;
  endtask

  task automatic doReset();
    rst_n = 0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int c = 0; c < 2; c++) begin
      mdl_owner[c] = -1; mdl_last[c] = 1; mdl_unack[c] = 0; mdl_abort[c] = 0;
    end
  endtask

  task automatic checkCfg(input int c, input logic [1:0] gnt, input logic scyc, input logic sstb,
                          input logic [31:0] sadr, input logic [31:0] sdat, input logic [3:0] ssel,
                          input logic swe, input logic [1:0] ack, input logic [1:0] err,
                          input logic to, input logic [31:0] d0, input logic [31:0] d1);
    bit busy;
    int o;
    logic cyc[2], stb[2], we[2];
    logic [31:0] adr[2], dat[2];
    logic [3:0] sel[2];
    logic [1:0] e_ack, e_err;
    cyc = '{m0_cyc, m1_cyc}; stb = '{m0_stb, m1_stb}; we = '{m0_we, m1_we};
    adr = '{m0_adr, m1_adr}; dat = '{m0_dat, m1_dat}; sel = '{m0_sel, m1_sel};
    busy = (mdl_owner[c] >= 0) && !mdl_abort[c];
    o = (mdl_owner[c] < 0) ? 0 : mdl_owner[c];
    for (int k = 0; k < 2; k++) begin
      e_ack[k] = busy && o == k && s_ack && stb[k];
      e_err[k] = (busy && o == k && s_err && stb[k]) || (mdl_abort[c] && mdl_owner[c] == k);
    end
    checkOutput($sformatf("rnd%0d gnt", c), gnt,
                mdl_owner[c] == 0 ? 2'b01 : mdl_owner[c] == 1 ? 2'b10 : 2'b00);
    checkOutput($sformatf("rnd%0d s_cyc", c), scyc, busy ? cyc[o] : 1'b0);
    checkOutput($sformatf("rnd%0d s_stb", c), sstb, busy ? stb[o] : 1'b0);
    checkOutput($sformatf("rnd%0d s_adr", c), sadr, busy ? adr[o] : 32'h0);
    checkOutput($sformatf("rnd%0d s_dat", c), sdat, busy ? dat[o] : 32'h0);
    checkOutput($sformatf("rnd%0d s_sel", c), ssel, busy ? sel[o] : 4'h0);
    checkOutput($sformatf("rnd%0d s_we", c), swe, busy ? we[o] : 1'b0);
    checkOutput($sformatf("rnd%0d ack", c), ack, e_ack);
    checkOutput($sformatf("rnd%0d err", c), err, e_err);
    checkOutput($sformatf("rnd%0d timeout", c), to, mdl_abort[c]);
    checkOutput($sformatf("rnd%0d dat0", c), d0, s_dat);
    checkOutput($sformatf("rnd%0d dat1", c), d1, s_dat);
  endtask

  task automatic modelStep(input int c);
    logic cyc[2], stb[2];
    bit r0, r1;
    int o, w;
    cyc = '{m0_cyc, m1_cyc}; stb = '{m0_stb, m1_stb};
    o = mdl_owner[c];
    if (mdl_abort[c]) begin
      mdl_owner[c] = -1;
      mdl_abort[c] = 0;
    end else if (o < 0) begin
      r0 = m0_cyc && m0_stb;
      r1 = m1_cyc && m1_stb;
      if (r0 && r1) w = (mdl_rr[c] != 0) ? 1 - mdl_last[c] : 0;
      else if (r0) w = 0;
      else if (r1) w = 1;
      else w = -1;
      if (w >= 0) begin
        mdl_owner[c] = w; mdl_last[c] = w; mdl_unack[c] = 0;
      end
    end else begin
      if (s_ack || s_err) mdl_unack[c] = 0;
      else if (stb[o]) begin
        mdl_unack[c]++;
        if (mdl_to[c] > 0 && mdl_unack[c] >= mdl_to[c]) mdl_abort[c] = 1;
      end
      if (!mdl_abort[c] && !cyc[o]) mdl_owner[c] = -1;
    end
  endtask

  initial begin
    // Hand-derived cycle table starting right after reset
    vec[0]  = '{1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{1, 1, 1, 0, 2'b01, 2'b01, 1, 1, 0, 0, 0, 0};
    vec[2]  = '{0, 1, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0};
    vec[3]  = '{1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
    vec[4]  = '{1, 1, 1, 1, 2'b10, 2'b01, 1, 0, 1, 0, 1, 0};
    vec[5]  = '{1, 0, 0, 0, 2'b10, 2'b01, 0, 0, 0, 0, 0, 0};
    vec[6]  = '{1, 1, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0};
    for (int i = 7; i <= 14; i++)
      vec[i] = '{1, 1, 0, 0, 2'b01, 2'b01, 1, 0, 0, 0, 0, 0};
    vec[15] = '{1, 1, 0, 0, 2'b01, 2'b01, 0, 0, 0, 1, 0, 1};
    vec[16] = '{1, 1, 0, 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0};

    // Reset state with requests already asserted
    rst_n = 0;
    clearInputs();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA5A5_0000; m1_cyc = 1; m1_stb = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst gnt", a_gnt, 2'b00);
    checkOutput("rst s_cyc", a_s_cyc, 1'b0);
    checkOutput("rst s_stb", a_s_stb, 1'b0);
    checkOutput("rst s_adr", a_s_adr, 32'h0);
    checkOutput("rst timeout", a_to, 1'b0);

    // Table: round-robin, held grants, dead cycle, watchdog abort
    doReset();
    for (int i = 0; i < 17; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(vec[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d gnt_a", i), a_gnt, vec[i].gnt_a);
      checkOutput($sformatf("vec%0d gnt_b", i), b_gnt, vec[i].gnt_b);
      checkOutput($sformatf("vec%0d s_cyc", i), a_s_cyc, vec[i].scyc);
      checkOutput($sformatf("vec%0d m0_ack", i), a_m0_ack, vec[i].a0);
      checkOutput($sformatf("vec%0d m1_ack", i), a_m1_ack, vec[i].a1);
      checkOutput($sformatf("vec%0d m0_err", i), a_m0_err, vec[i].e0);
      checkOutput($sformatf("vec%0d m1_err", i), a_m1_err, vec[i].e1);
      checkOutput($sformatf("vec%0d timeout", i), a_to, vec[i].to);
      checkOutput($sformatf("vec%0d m1_ack_b", i), b_m1_ack, 1'b0);
    end

    // m0 alone reads 0x1000_0004, slave acks on the third busy cycle
    doReset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1000_0004; m0_sel = 4'hF;
    @(negedge clk);
    checkOutput("rd s_cyc N", a_s_cyc, 1'b0);
    @(negedge clk);
    checkOutput("rd s_cyc N+1", a_s_cyc, 1'b1);
    checkOutput("rd gnt", a_gnt, 2'b01);
    checkOutput("rd s_adr", a_s_adr, 32'h1000_0004);
    checkOutput("rd s_we", a_s_we, 1'b0);
    @(negedge clk);
    checkOutput("rd ack early", a_m0_ack, 1'b0);
    @(posedge clk);
    #1 s_ack = 1; s_dat = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("rd ack", a_m0_ack, 1'b1);
    checkOutput("rd dat", a_m0_dat, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 clearInputs();

    // m1 owner: ack on the cycle the watchdog would fire, then async reset
    doReset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0040;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1 s_ack = 1;
    @(negedge clk);
    checkOutput("wd ack", a_m1_ack, 1'b1);
    @(posedge clk);
    #1 s_ack = 0;
    @(negedge clk);
    checkOutput("wd no timeout", a_to, 1'b0);
    checkOutput("wd still busy", a_s_cyc, 1'b1);
    checkOutput("wd gnt", a_gnt, 2'b10);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    checkOutput("async gnt", a_gnt, 2'b00);
    checkOutput("async s_cyc", a_s_cyc, 1'b0);
    @(posedge clk);
    #1 rst_n = 1;
    m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    checkOutput("post rst idle", a_gnt, 2'b00);
    @(negedge clk);
    checkOutput("post rst tie", a_gnt, 2'b01);

    // m0 write with partial selects while m1 waits; slave acks and errs
    doReset();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'b0011;
    m0_adr = 32'h2000_0010; m0_dat = 32'h1234_5678;
    m1_cyc = 1; m1_stb = 1; m1_sel = 4'b1100;
    @(posedge clk);
    #1 s_ack = 1; s_err = 1;
    @(negedge clk);
    checkOutput("wr m0_ack", a_m0_ack, 1'b1);
    checkOutput("wr m0_err", a_m0_err, 1'b1);
    checkOutput("wr m1_ack", a_m1_ack, 1'b0);
    checkOutput("wr m1_err", a_m1_err, 1'b0);
    checkOutput("wr s_sel", a_s_sel, 4'b0011);
    checkOutput("wr s_we", a_s_we, 1'b1);
    checkOutput("wr s_dat", a_s_dat, 32'h1234_5678);

    // Randomized traffic against the reference model for both instances
    doReset();
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (m0_cyc) m0_cyc = ($urandom_range(0, 5) != 0);
      else        m0_cyc = ($urandom_range(0, 2) == 0);
      if (m1_cyc) m1_cyc = ($urandom_range(0, 5) != 0);
      else        m1_cyc = ($urandom_range(0, 2) == 0);
      m0_stb = m0_cyc && ($urandom_range(0, 3) != 0);
      m1_stb = m1_cyc && ($urandom_range(0, 3) != 0);
      m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom); m0_we = 1'($urandom);
      m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom); m1_we = 1'($urandom);
      s_ack = ($urandom_range(0, 9) == 0);
      s_err = ($urandom_range(0, 39) == 0);
      s_dat = $urandom;
      @(negedge clk);
      checkCfg(0, a_gnt, a_s_cyc, a_s_stb, a_s_adr, a_s_dat, a_s_sel, a_s_we,
               {a_m1_ack, a_m0_ack}, {a_m1_err, a_m0_err}, a_to, a_m0_dat, a_m1_dat);
      checkCfg(1, b_gnt, b_s_cyc, b_s_stb, b_s_adr, b_s_dat, b_s_sel, b_s_we,
               {b_m1_ack, b_m0_ack}, {b_m1_err, b_m0_err}, b_to, b_m0_dat, b_m1_dat);
      modelStep(0);
      modelStep(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
